// File: rtl/bcd_digit_sender.sv
// bcd_digit_sender: sends a captured BCD code one digit at a time over valid/ready, with a seven-segment image of the digit on the link
module bcd_digit_sender #(
  parameter int NUM_DIGITS = 2,
  parameter int GAP_CYCLES = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [4*NUM_DIGITS-1:0] code,
  input  logic                    digit_ready,
  output logic                    digit_valid,
  output logic [3:0]              digit_data,
  output logic [2:0]              digit_idx,
  output logic                    busy,
  output logic                    done,
  output logic [6:0]              seg
);
  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;
  state_t state, state_n;
  logic [4*NUM_DIGITS-1:0] code_q, code_n, shifted;
  logic [2:0] idx, idx_n;
  logic [7:0] cnt, cnt_n;
  logic hs, last;
  assign shifted     = code_q >> (4 * idx);
  assign digit_valid = state == SEND;
  assign digit_data  = digit_valid ? shifted[3:0] : 4'd0;
  assign digit_idx   = idx;
  assign busy        = state == SEND || state == GAP;
  assign done        = state == DONE;
  assign hs          = digit_valid && digit_ready;
  assign last        = idx == 3'(NUM_DIGITS - 1);
  // state, captured code, digit index and gap counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      code_q <= '0;
      idx    <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_n;
      code_q <= code_n;
      idx    <= idx_n;
      cnt    <= cnt_n;
    end
  end
  // next-state: capture on start, advance on handshake, hold off for the inter-digit gap
  always_comb begin
    state_n = state;
    code_n  = code_q;
    idx_n   = idx;
    cnt_n   = cnt;
    case (state)
      IDLE: if (start) begin
        state_n = SEND;
        code_n  = code;
        idx_n   = '0;
        cnt_n   = '0;
      end
      SEND: if (hs) begin
        if (last) state_n = DONE;
        else begin
          idx_n   = idx + 3'd1;
          state_n = GAP_CYCLES > 0 ? GAP : SEND;
        end
      end
      GAP: begin
        state_n = cnt == 8'(GAP_CYCLES - 1) ? SEND : GAP;
        cnt_n   = cnt == 8'(GAP_CYCLES - 1) ? 8'd0 : cnt + 8'd1;
      end
      DONE: begin
        state_n = IDLE;
        idx_n   = '0;
      end
    endcase
  end
  // active-low seven-segment decode, blank when idle or non-BCD
  always_comb begin
    seg = 7'h7f;
    if (digit_valid)
      case (digit_data)
        4'd0: seg = 7'h40;
        4'd1: seg = 7'h79;
        4'd2: seg = 7'h24;
        4'd3: seg = 7'h30;
        4'd4: seg = 7'h19;
        4'd5: seg = 7'h12;
        4'd6: seg = 7'h02;
        4'd7: seg = 7'h78;
        4'd8: seg = 7'h00;
        4'd9: seg = 7'h10;
        default: seg = 7'h7f;
      endcase
  end
endmodule

// File: tb/tb_bcd_digit_sender.sv
// tb_bcd_digit_sender: directed vector table plus hand sequences for stall, no-gap, and mid-gap reset
module tb_bcd_digit_sender;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;
  logic s0 = 1'b0, r0 = 1'b0;
  logic [7:0] c0 = 8'h00;
  logic v0, b0, dn0;
  logic [3:0] d0;
  logic [2:0] i0;
  logic [6:0] sg0;
  logic s1 = 1'b0, r1 = 1'b0;
  logic [11:0] c1 = 12'h000;
  logic v1, b1, dn1;
  logic [3:0] d1;
  logic [2:0] i1;
  logic [6:0] sg1;
  int n_chk = 0;
  int n_fail = 0;
  bcd_digit_sender #(.NUM_DIGITS(2), .GAP_CYCLES(3)) u0 (
    .clk(clk), .reset_n(reset_n), .start(s0), .code(c0), .digit_ready(r0),
    .digit_valid(v0), .digit_data(d0), .digit_idx(i0), .busy(b0), .done(dn0), .seg(sg0));
  bcd_digit_sender #(.NUM_DIGITS(3), .GAP_CYCLES(0)) u1 (
    .clk(clk), .reset_n(reset_n), .start(s1), .code(c1), .digit_ready(r1),
    .digit_valid(v1), .digit_data(d1), .digit_idx(i1), .busy(b1), .done(dn1), .seg(sg1));
  typedef struct {
    logic st; logic [7:0] cd; logic rd;
    logic v; logic [3:0] d; logic [2:0] i; logic b; logic dn; logic [6:0] sg;
  } vec_t;
  vec_t tbl[24];
  function automatic vec_t mk(logic st, logic [7:0] cd, logic rd, logic v, logic [3:0] d,
                              logic [2:0] i, logic b, logic dn, logic [6:0] sg);
    vec_t t;
    t.st = st; t.cd = cd; t.rd = rd; t.v = v; t.d = d; t.i = i; t.b = b; t.dn = dn; t.sg = sg;
    return t;
  endfunction
  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, row, act, exp);
    end
  endtask
  task automatic chk0(input int row, input logic v, input logic [3:0] d, input logic [2:0] i,
                      input logic b, input logic dn, input logic [6:0] sg);
    chk("valid", row, 32'(v0), 32'(v));
    chk("data", row, 32'(d0), 32'(d));
    if (i != 3'd7) chk("idx", row, 32'(i0), 32'(i));
    chk("busy", row, 32'(b0), 32'(b));
    chk("done", row, 32'(dn0), 32'(dn));
    chk("seg", row, 32'(sg0), 32'(sg));
  endtask
  initial begin
    tbl[0]  = mk(1'b1, 8'h45, 1'b1, 1'b0, 4'h0, 3'd0, 1'b0, 1'b0, 7'h7f);
    tbl[1]  = mk(1'b0, 8'h45, 1'b1, 1'b1, 4'h5, 3'd0, 1'b1, 1'b0, 7'h12);
    tbl[2]  = mk(1'b0, 8'h45, 1'b1, 1'b0, 4'h0, 3'd1, 1'b1, 1'b0, 7'h7f);
    tbl[3]  = mk(1'b0, 8'h45, 1'b1, 1'b0, 4'h0, 3'd1, 1'b1, 1'b0, 7'h7f);
    tbl[4]  = mk(1'b0, 8'h45, 1'b1, 1'b0, 4'h0, 3'd1, 1'b1, 1'b0, 7'h7f);
    tbl[5]  = mk(1'b0, 8'h45, 1'b1, 1'b1, 4'h4, 3'd1, 1'b1, 1'b0, 7'h19);
    tbl[6]  = mk(1'b0, 8'h45, 1'b1, 1'b0, 4'h0, 3'd7, 1'b0, 1'b1, 7'h7f);
    tbl[7]  = mk(1'b0, 8'h45, 1'b1, 1'b0, 4'h0, 3'd7, 1'b0, 1'b0, 7'h7f);
    tbl[8]  = mk(1'b1, 8'h45, 1'b1, 1'b0, 4'h0, 3'd7, 1'b0, 1'b0, 7'h7f);
    tbl[9]  = mk(1'b1, 8'h99, 1'b1, 1'b1, 4'h5, 3'd0, 1'b1, 1'b0, 7'h12);
    tbl[10] = mk(1'b1, 8'h99, 1'b1, 1'b0, 4'h0, 3'd1, 1'b1, 1'b0, 7'h7f);
    tbl[11] = mk(1'b1, 8'h99, 1'b1, 1'b0, 4'h0, 3'd1, 1'b1, 1'b0, 7'h7f);
    tbl[12] = mk(1'b0, 8'h99, 1'b1, 1'b0, 4'h0, 3'd1, 1'b1, 1'b0, 7'h7f);
    tbl[13] = mk(1'b1, 8'h99, 1'b1, 1'b1, 4'h4, 3'd1, 1'b1, 1'b0, 7'h19);
    tbl[14] = mk(1'b1, 8'h99, 1'b1, 1'b0, 4'h0, 3'd7, 1'b0, 1'b1, 7'h7f);
    tbl[15] = mk(1'b0, 8'h4a, 1'b1, 1'b0, 4'h0, 3'd7, 1'b0, 1'b0, 7'h7f);
    tbl[16] = mk(1'b1, 8'h4a, 1'b1, 1'b0, 4'h0, 3'd7, 1'b0, 1'b0, 7'h7f);
    tbl[17] = mk(1'b0, 8'h4a, 1'b1, 1'b1, 4'ha, 3'd0, 1'b1, 1'b0, 7'h7f);
    tbl[18] = mk(1'b0, 8'h4a, 1'b1, 1'b0, 4'h0, 3'd1, 1'b1, 1'b0, 7'h7f);
    tbl[19] = mk(1'b0, 8'h4a, 1'b1, 1'b0, 4'h0, 3'd1, 1'b1, 1'b0, 7'h7f);
    tbl[20] = mk(1'b0, 8'h4a, 1'b1, 1'b0, 4'h0, 3'd1, 1'b1, 1'b0, 7'h7f);
    tbl[21] = mk(1'b0, 8'h4a, 1'b1, 1'b1, 4'h4, 3'd1, 1'b1, 1'b0, 7'h19);
    tbl[22] = mk(1'b0, 8'h4a, 1'b1, 1'b0, 4'h0, 3'd7, 1'b0, 1'b1, 7'h7f);
    tbl[23] = mk(1'b0, 8'h4a, 1'b1, 1'b0, 4'h0, 3'd7, 1'b0, 1'b0, 7'h7f);
    #2 reset_n = 1'b0;
    @(negedge clk);
    chk0(100, 1'b0, 4'h0, 3'd0, 1'b0, 1'b0, 7'h7f);
    chk("rst_valid1", 100, 32'(v1), 32'd0);
    chk("rst_seg1", 100, 32'(sg1), 32'h7f);
    reset_n = 1'b1;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      s0 = tbl[k].st; c0 = tbl[k].cd; r0 = tbl[k].rd;
      chk0(k, tbl[k].v, tbl[k].d, tbl[k].i, tbl[k].b, tbl[k].dn, tbl[k].sg);
    end
    @(negedge clk);
    s0 = 1'b1; c0 = 8'h45; r0 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      s0 = 1'b0;
      chk0(200 + k, 1'b1, 4'h5, 3'd0, 1'b1, 1'b0, 7'h12);
    end
    @(negedge clk);
    chk0(205, 1'b1, 4'h5, 3'd0, 1'b1, 1'b0, 7'h12);
    r0 = 1'b1;
    @(negedge clk);
    chk0(206, 1'b0, 4'h0, 3'd1, 1'b1, 1'b0, 7'h7f);
    begin
      int w;
      w = 0;
      while (!dn0 && w < 20) begin
        @(negedge clk);
        w++;
      end
      chk("stall_done_seen", 207, 32'(dn0), 32'd1);
      chk("stall_done_latency", 207, 32'(w), 32'd4);
    end
    @(negedge clk);
    s1 = 1'b1; c1 = 12'h123; r1 = 1'b1;
    @(negedge clk);
    s1 = 1'b0;
    chk("nogap_d0", 300, {v1, d1, i1, sg1}, {1'b1, 4'h3, 3'd0, 7'h30});
    @(negedge clk);
    chk("nogap_d1", 301, {v1, d1, i1, sg1}, {1'b1, 4'h2, 3'd1, 7'h24});
    @(negedge clk);
    chk("nogap_d2", 302, {v1, d1, i1, sg1}, {1'b1, 4'h1, 3'd2, 7'h79});
    @(negedge clk);
    chk("nogap_done", 303, {v1, b1, dn1}, {1'b0, 1'b0, 1'b1});
    @(negedge clk);
    chk("nogap_idle", 304, {v1, b1, dn1}, {1'b0, 1'b0, 1'b0});
    s0 = 1'b1; c0 = 8'h45; r0 = 1'b1;
    @(negedge clk);
    s0 = 1'b0;
    chk0(400, 1'b1, 4'h5, 3'd0, 1'b1, 1'b0, 7'h12);
    @(negedge clk);
    chk0(401, 1'b0, 4'h0, 3'd1, 1'b1, 1'b0, 7'h7f);
    @(negedge clk);
    chk0(402, 1'b0, 4'h0, 3'd1, 1'b1, 1'b0, 7'h7f);
    #2 reset_n = 1'b0;
    #1 chk0(403, 1'b0, 4'h0, 3'd0, 1'b0, 1'b0, 7'h7f);
    @(negedge clk);
    chk0(404, 1'b0, 4'h0, 3'd0, 1'b0, 1'b0, 7'h7f);
    reset_n = 1'b1;
    s0 = 1'b1; c0 = 8'h45;
    @(negedge clk);
    s0 = 1'b0;
    chk0(405, 1'b1, 4'h5, 3'd0, 1'b1, 1'b0, 7'h12);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk0(406 + k, 1'b0, 4'h0, 3'd1, 1'b1, 1'b0, 7'h7f);
    end
    @(negedge clk);
    chk0(409, 1'b1, 4'h4, 3'd1, 1'b1, 1'b0, 7'h19);
    @(negedge clk);
    chk0(410, 1'b0, 4'h0, 3'd7, 1'b0, 1'b1, 7'h7f);
    @(negedge clk);
    chk0(411, 1'b0, 4'h0, 3'd7, 1'b0, 1'b0, 7'h7f);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bcd_digit_sender.md
BCD_DIGIT_SENDER -- requirements
Module: bcd_digit_sender

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 2, number of BCD digits per code (legal 1..6).
REQ-002 SHALL have parameter GAP_CYCLES, default 3, idle cycles between digits (legal 0..255).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request to send the code on `code`.
REQ-006 SHALL have port code  input  4*NUM_DIGITS  digits, digit 0 in bits [3:0].
REQ-007 SHALL have port digit_ready  input  1  sink accepts digit_data this cycle.
REQ-008 SHALL have port digit_valid  output  1  digit_data holds a valid digit.
REQ-009 SHALL have port digit_data  output  4  current digit value.
REQ-010 SHALL have port digit_idx  output  3  index of the current digit.
REQ-011 SHALL have port busy  output  1  transfer in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse when a transfer completes.
REQ-013 SHALL have port seg  output  7  active-low seven-segment image of the digit being sent.

Function
REQ-014 SHALL implement states IDLE, SEND, GAP and DONE.
REQ-015 In IDLE, start=1 SHALL capture `code` into an internal register, set digit_idx=0 and enter SEND; digit_valid SHALL be 1 on the cycle after start is sampled.
REQ-016 start SHALL be ignored in SEND, GAP and DONE; changes to `code` after capture SHALL have no effect.
REQ-017 In SEND, digit_valid=1 and digit_data=captured digit[digit_idx]; both SHALL stay stable until the cycle in which digit_valid and digit_ready are both 1 (handshake).
REQ-018 On a handshake with digit_idx=NUM_DIGITS-1, the block SHALL enter DONE, with no gap after the last digit.
REQ-019 On any other handshake, digit_idx SHALL increment, and the block SHALL enter GAP if GAP_CYCLES>0; otherwise it stays in SEND and presents the next digit on the next cycle.
REQ-020 GAP SHALL last exactly GAP_CYCLES cycles, counted by an 8-bit counter, with digit_valid=0, then return to SEND.
REQ-021 DONE SHALL last exactly one cycle with done=1, then go to IDLE; done SHALL be 0 in all other states.
REQ-022 busy SHALL be 1 in SEND and GAP and 0 in IDLE and DONE.
REQ-023 digit_data SHALL be 0 whenever digit_valid=0; digit_ready SHALL be ignored whenever digit_valid=0.
REQ-024 When digit_valid=1, seg SHALL decode digit_data as follows: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-025 seg SHALL be 1111111 (blank) when digit_valid=0 or digit_data>9.
REQ-026 Non-BCD digits (10..15) SHALL still be transmitted unchanged.
REQ-027 Digits SHALL be sent in order 0 to NUM_DIGITS-1, and digit_idx SHALL never exceed NUM_DIGITS-1.

Reset
REQ-028 reset_n=0 SHALL immediately force IDLE, digit_valid=0, digit_data=0, digit_idx=0, busy=0, done=0, seg=1111111, gap counter=0, and captured code=0.
REQ-029 Reset during SEND or GAP SHALL abort the transfer without a done pulse; start SHALL be honoured on the first clock edge after reset_n returns to 1.

Verification
REQ-030 Bench SHALL cover: defaults, code=8'h45, ready=1, start pulse in cycle 0 -> valid/data=5/seg=0010010 in cycle 1; valid=0 in cycles 2-4; valid/data=4/seg=0011001 in cycle 5; done=1 in cycle 6; busy=0 and IDLE in cycle 7.
REQ-031 Bench SHALL cover: digit_ready=0 for 5 cycles during the first digit -> digit_valid=1, digit_data=5 and digit_idx=0 held constant; the handshake completes on the first ready=1 cycle.
REQ-032 Bench SHALL cover: start re-pulsed while busy, and code changed to 8'h99 mid-transfer -> the sequence is still 5,4 with exactly one done pulse.
REQ-033 Bench SHALL cover: GAP_CYCLES=0, NUM_DIGITS=3, code=12'h123, ready=1 -> data 3,2,1 on three consecutive cycles, then done.
REQ-034 Bench SHALL cover: code=8'h4A -> digit 0xA transmitted with seg=1111111, then digit 4.
REQ-035 Bench SHALL cover: reset_n=0 in the second GAP cycle -> all outputs at reset values asynchronously, no done pulse; a new start then sends the full code from digit 0.
